// File: rtl/rule_arb_pkg.sv
// rtl/rule_arb_pkg.sv - shared types, defaults and round-robin pick helper for the rule arbiter
//
// Purpose : common definitions for rule_stream_arbiter and rr_arbiter_core.
// Contents: arb_state_e (IDLE/LOCK), RULE_DW/RULE_EW defaults, rr_pick().
package rule_arb_pkg;

  localparam int unsigned RULE_DW = 128;
  localparam int unsigned RULE_EW = 4;
  localparam int unsigned MAX_SRC = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Search valid[] starting at ptr, wrapping modulo n (n <= MAX_SRC).
  // Returns {found, index}; index falls back to ptr when nothing is found.
  function automatic logic [3:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic       found;
    logic [2:0] idx;
    logic [3:0] j;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      // ptr < n, so one conditional subtract is enough to wrap
      j = {1'b0, ptr} + 4'(k);
      if (j >= n) j = j - n;
      if (!found && (4'(k) < n) && valid[j[2:0]]) begin
        found = 1'b1;
        idx   = j[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// rtl/rr_arbiter_core.sv - combinational rotate and priority-encode round-robin stage
//
// Purpose : picks the first requester at or after ptr_i, wrapping modulo N.
// Ports   : req_i   [N-1:0] request vector
//           ptr_i   [2:0]   round-robin start position (must be < N)
//           found_o         at least one request present
//           idx_o   [2:0]   winning index (ptr_i when none found)
module rr_arbiter_core
  import rule_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic         found_o,
  output logic [2:0]   idx_o
);

  logic [7:0] req_pad;
  logic [3:0] pick;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req_i;
  end

  assign pick             = rr_pick(req_pad, ptr_i, 4'(N));
  assign {found_o, idx_o} = pick;

endmodule

// File: rtl/rule_stream_arbiter.sv
// rtl/rule_stream_arbiter.sv - packet-atomic round-robin merge of N_SRC rule streams
//
// Purpose : merges N_SRC beat streams into one register-sliced output; a granted
//           source keeps the grant from sop through eop.
// Ports   : clk, rst_n (async, active-low)
//           in_rule_{sop,eop,valid} [N_SRC], in_rule_empty [N_SRC*EW],
//           in_rule_data [N_SRC*DW], in_rule_ready [N_SRC] (out)
//           out_rule_{sop,eop,valid,empty,data} (out), out_rule_ready (in)
//           cur_src [3] locked / last-granted source, proto_err sticky flag
// Options : RULE_ARB_STATS_EN adds pkt_cnt [N_SRC*16] (out) and stats_clr (in).
module rule_stream_arbiter
  import rule_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DW    = RULE_DW,
  parameter int EW    = RULE_EW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC-1:0]    in_rule_sop,
  input  logic [N_SRC-1:0]    in_rule_eop,
  input  logic [N_SRC*EW-1:0] in_rule_empty,
  input  logic [N_SRC-1:0]    in_rule_valid,
  input  logic [N_SRC*DW-1:0] in_rule_data,
  output logic [N_SRC-1:0]    in_rule_ready,
  output logic                out_rule_sop,
  output logic                out_rule_eop,
  output logic [EW-1:0]       out_rule_empty,
  output logic                out_rule_valid,
  output logic [DW-1:0]       out_rule_data,
  input  logic                out_rule_ready,
  output logic [2:0]          cur_src,
  output logic                proto_err
`ifdef RULE_ARB_STATS_EN
  ,
  output logic [N_SRC*16-1:0] pkt_cnt,
  input  logic                stats_clr
`endif
);

  arb_state_e state_q, state_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] cur_src_q, cur_src_d;
  logic       proto_err_q, proto_err_d;

  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [EW-1:0] out_empty_q, out_empty_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          arb_found;
  logic [2:0]    arb_idx;
  logic          grant_en;
  logic [2:0]    grant_idx;
  logic          slot_free;
  logic          accept;
  logic          sel_sop;
  logic          sel_eop;
  logic [EW-1:0] sel_empty;
  logic [DW-1:0] sel_data;

  function automatic logic [2:0] rr_next(input logic [2:0] i);
    return (i == 3'(N_SRC - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  rr_arbiter_core #(
    .N (N_SRC)
  ) u_rr_core (
    .req_i   (in_rule_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // The output register can take a beat whenever it is empty or draining.
  assign slot_free = !out_valid_q || out_rule_ready;

  // Grant select and beat mux. In LOCK the grant ignores the arbiter so
  // valid gaps of the owning source never release the lock.
  always_comb begin
    grant_idx     = (state_q == LOCK) ? cur_src_q : arb_idx;
    grant_en      = (state_q == LOCK) || arb_found;
    in_rule_ready = '0;
    accept        = 1'b0;
    sel_sop       = 1'b0;
    sel_eop       = 1'b0;
    sel_empty     = '0;
    sel_data      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_idx == 3'(i)) begin
        in_rule_ready[i] = grant_en && slot_free;
        accept           = grant_en && slot_free && in_rule_valid[i];
        sel_sop          = in_rule_sop[i];
        sel_eop          = in_rule_eop[i];
        sel_empty        = in_rule_empty[i*EW +: EW];
        sel_data         = in_rule_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_src_d   = cur_src_q;
    proto_err_d = proto_err_q;

    out_valid_d = accept || (out_valid_q && !out_rule_ready);
    out_sop_d   = accept ? sel_sop   : out_sop_q;
    out_eop_d   = accept ? sel_eop   : out_eop_q;
    out_empty_d = accept ? sel_empty : out_empty_q;
    out_data_d  = accept ? sel_data  : out_data_q;

    if (accept) begin
      cur_src_d = grant_idx;
      // A packet must open in IDLE and must not reopen while locked;
      // the beat is forwarded either way.
      if ((state_q == IDLE) ? !sel_sop : sel_sop) proto_err_d = 1'b1;
      if (sel_eop) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next(grant_idx);
      end else begin
        state_d  = LOCK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_src_q   <= '0;
      proto_err_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_src_q   <= cur_src_d;
      proto_err_q <= proto_err_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_rule_sop   = out_sop_q;
  assign out_rule_eop   = out_eop_q;
  assign out_rule_empty = out_empty_q;
  assign out_rule_valid = out_valid_q;
  assign out_rule_data  = out_data_q;
  assign cur_src        = cur_src_q;
  assign proto_err      = proto_err_q;

`ifdef RULE_ARB_STATS_EN
  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    logic [15:0] cnt_q;
    // Clear has priority over a coincident packet completion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (stats_clr) begin
        cnt_q <= '0;
      end else if (accept && sel_eop && (grant_idx == 3'(g))) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign pkt_cnt[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// tb/tb_rule_stream_arbiter.sv - directed scoreboard bench for rule_stream_arbiter
module tb_rule_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int EW = 4;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [2:0] src;
    beat_t      b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_rule_sop;
  logic [N-1:0]    in_rule_eop;
  logic [N*EW-1:0] in_rule_empty;
  logic [N-1:0]    in_rule_valid;
  logic [N*DW-1:0] in_rule_data;
  logic [N-1:0]    in_rule_ready;
  logic            out_rule_sop;
  logic            out_rule_eop;
  logic [EW-1:0]   out_rule_empty;
  logic            out_rule_valid;
  logic [DW-1:0]   out_rule_data;
  logic            out_rule_ready;
  logic [2:0]      cur_src;
  logic            proto_err;
`ifdef RULE_ARB_STATS_EN
  logic [N*16-1:0] pkt_cnt;
  logic            stats_clr;
`endif

  logic [N-1:0] drv_valid;
  logic [N-1:0] gap_mask;
  logic [N-1:0] hs;
  assign in_rule_valid = drv_valid & ~gap_mask;

  beat_t       srcq [N][$];
  exp_t        exp_q[$];
  int unsigned xfer_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  rule_stream_arbiter #(
    .N_SRC (N),
    .DW    (DW),
    .EW    (EW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_rule_sop    (in_rule_sop),
    .in_rule_eop    (in_rule_eop),
    .in_rule_empty  (in_rule_empty),
    .in_rule_valid  (in_rule_valid),
    .in_rule_data   (in_rule_data),
    .in_rule_ready  (in_rule_ready),
    .out_rule_sop   (out_rule_sop),
    .out_rule_eop   (out_rule_eop),
    .out_rule_empty (out_rule_empty),
    .out_rule_valid (out_rule_valid),
    .out_rule_data  (out_rule_data),
    .out_rule_ready (out_rule_ready),
    .cur_src        (cur_src),
    .proto_err      (proto_err)
`ifdef RULE_ARB_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .stats_clr      (stats_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mkb(int s, int p, int k, int n, logic [3:0] e);
    beat_t b;
    b.sop   = (k == 0);
    b.eop   = (k == n - 1);
    b.empty = b.eop ? e : 4'(k + 1);
    b.data  = {32'(s) | 32'hA500_0000, 32'(p), 32'(k), 32'h0BAD_F00D};
    return b;
  endfunction

  task automatic send(int s, int p, int n, logic [3:0] e);
    for (int k = 0; k < n; k++) srcq[s].push_back(mkb(s, p, k, n, e));
  endtask

  task automatic expect_pkt(int s, int p, int n, logic [3:0] e);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.src = 3'(s);
      x.b   = mkb(s, p, k, n, e);
      exp_q.push_back(x);
    end
  endtask

  // Inputs change at posedge+2 from the main sequence.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      step();
      t++;
    end
    step();
    check(tag, 160'(exp_q.size()), 160'd0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 160'(out_rule_valid), 160'd0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Source drivers: pop a beat after its handshake, present the next one.
  initial begin
    beat_t b;
    drv_valid     = '0;
    in_rule_sop   = '0;
    in_rule_eop   = '0;
    in_rule_empty = '0;
    in_rule_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (rst_n && srcq[i].size() > 0) begin
          b = srcq[i][0];
          drv_valid[i]                = 1'b1;
          in_rule_sop[i]              = b.sop;
          in_rule_eop[i]              = b.eop;
          in_rule_empty[i*EW +: EW]   = b.empty;
          in_rule_data[i*DW +: DW]    = b.data;
        end else begin
          drv_valid[i] = 1'b0;
        end
      end
    end
  end

  // Handshake capture and output scoreboard, sampled mid-cycle.
  initial begin
    exp_t obs;
    exp_t e;
    hs = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) hs[i] = rst_n && in_rule_valid[i] && in_rule_ready[i];
      if (rst_n && out_rule_valid && out_rule_ready) begin
        obs.src     = cur_src;
        obs.b.sop   = out_rule_sop;
        obs.b.eop   = out_rule_eop;
        obs.b.empty = out_rule_empty;
        obs.b.data  = out_rule_data;
        xfer_q.push_back(cyc);
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed %0h expected none", obs);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_beat", 160'(obs), 160'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    beat_t       bad;
    exp_t        x;

    gap_mask       = '0;
    out_rule_ready = 1'b1;
`ifdef RULE_ARB_STATS_EN
    stats_clr      = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 160'(out_rule_valid), 160'd0);
    check("rst_out_sop",   160'(out_rule_sop),   160'd0);
    check("rst_out_eop",   160'(out_rule_eop),   160'd0);
    check("rst_out_empty", 160'(out_rule_empty), 160'd0);
    check("rst_out_data",  160'(out_rule_data),  160'd0);
    check("rst_in_ready",  160'(in_rule_ready),  160'd0);
    check("rst_cur_src",   160'(cur_src),        160'd0);
    check("rst_proto_err", 160'(proto_err),      160'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single 3-beat packet from source 0.
    xfer_q.delete();
    k = cyc;
    send(0, 1, 3, 4);
    expect_pkt(0, 1, 3, 4);
    drain("t1_drain", 20);
    check("t1_count", 160'(xfer_q.size()), 160'd3);
    check("t1_first", 160'((xfer_q.size() > 0) ? xfer_q[0] : 0), 160'(k + 2));
    check("t1_last",  160'((xfer_q.size() > 2) ? xfer_q[2] : 0), 160'(k + 4));

    // rr_ptr is now 1: source 1 must beat source 0.
    send(0, 2, 1, 0);
    send(1, 2, 1, 0);
    expect_pkt(1, 2, 1, 0);
    expect_pkt(0, 2, 1, 0);
    drain("t1_rr_drain", 20);

    // All sources busy with 2-beat packets from a fresh pointer.
    do_reset();
    step();
    xfer_q.delete();
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < N; s++) begin
        send(s, 10 + p, 2, 4'(s));
        expect_pkt(s, 10 + p, 2, 4'(s));
      end
    end
    drain("t2_drain", 60);
    check("t2_count", 160'(xfer_q.size()), 160'd16);
    check("t2_span", 160'((xfer_q.size() == 16) ? xfer_q[15] - xfer_q[0] : 0), 160'd15);

    // Source 2 holds its lock through a valid gap while source 1 waits.
    step();
    send(2, 3, 4, 7);
    expect_pkt(2, 3, 4, 7);
    step();
    step();
    gap_mask[2] = 1'b1;
    send(1, 3, 2, 5);
    expect_pkt(1, 3, 2, 5);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      check("t3_ready1", 160'(in_rule_ready[1]), 160'd0);
      check("t3_cur_src", 160'(cur_src), 160'd2);
      step();
    end
    gap_mask[2] = 1'b0;
    drain("t3_drain", 30);

    // Backpressure 1,0,0,1 during a 4-beat packet.
    step();
    send(3, 4, 4, 2);
    expect_pkt(3, 4, 4, 2);
    step();
    step();
    step();
    out_rule_ready = 1'b0;
    step();
    @(negedge clk);
    check("t4_hold_valid", 160'(out_rule_valid), 160'd1);
    check("t4_hold_data", 160'(out_rule_data), 160'(mkb(3, 4, 1, 4, 2).data));
    check("t4_stall_ready", 160'(in_rule_ready[3]), 160'd0);
    step();
    out_rule_ready = 1'b1;
    drain("t4_drain", 30);

    // Beat without sop while idle: forwarded, proto_err sticks until reset.
    step();
    bad     = mkb(0, 5, 0, 1, 9);
    bad.sop = 1'b0;
    srcq[0].push_back(bad);
    x.src = 3'd0;
    x.b   = bad;
    exp_q.push_back(x);
    step();
    @(negedge clk);
    check("t5_err_before", 160'(proto_err), 160'd0);
    step();
    @(negedge clk);
    check("t5_err_set", 160'(proto_err), 160'd1);
    repeat (5) step();
    check("t5_err_sticky", 160'(proto_err), 160'd1);
    check("t5_drain", 160'(exp_q.size()), 160'd0);
    do_reset();
    @(negedge clk);
    check("t5_err_cleared", 160'(proto_err), 160'd0);

`ifdef RULE_ARB_STATS_EN
    step();
    for (int p = 0; p < 5; p++) begin
      send(3, 20 + p, 1, 1);
      expect_pkt(3, 20 + p, 1, 1);
    end
    drain("t6_drain", 30);
    check("t6_cnt3", 160'(pkt_cnt[3*16 +: 16]), 160'd5);
    check("t6_cnt_others", 160'(pkt_cnt[47:0]), 160'd0);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    @(negedge clk);
    check("t6_cnt_cleared", 160'(pkt_cnt), 160'd0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
